vga_zoom_display: RTL and testbench
===================================

Name: vga_zoom_display

Overview:
- Downstream display stage for the zoom-out path. Generates 640x480@60 VGA timing from the 100 MHz system clock and drives the zoom engine's x_vga/y_vga/flow_enabled request interface.
- Consumes the engine's pixel_out/pixel_valid stream and centres the reduced image (IMG_WIDTH>>k by IMG_HEIGHT>>k) on screen. Border colour fills the rest of the active area; blanking is zero.

Parameters:
IMG_WIDTH, 160, source image width in pixels
IMG_HEIGHT, 120, source image height in pixels
DATA_WIDTH, 8, greyscale pixel width
LOOKAHEAD, 2, pixel slots by which requests lead the display position (1..4)
BORDER_COLOR, 8'h00, value shown in active area outside the image window

Ports:
clk  input  1  100 MHz system clock
reset  input  1  synchronous, active-high
k  input  2  zoom-out factor exponent (window = IMG>>k)
x_vga  output  10  requested column within window (0 when outside)
y_vga  output  10  requested row within window (0 when outside)
flow_enabled  output  1  high for the whole slot of an in-window request
pixel_in  input  DATA_WIDTH  pixel from zoom engine
pixel_valid_in  input  1  pixel_in valid this clock
hsync  output  1  active-low horizontal sync
vsync  output  1  active-low vertical sync
video_on  output  1  high during 640x480 active area
pixel_rgb  output  DATA_WIDTH  greyscale pixel to DAC
frame_start  output  1  one-clock pulse at the start of slot (0,0)

Behaviour:
- All state updates on posedge clk. reset has priority over all other logic.
- Reset values: tick=0, display counters (h,v)=(0,0), request counters=(LOOKAHEAD,0), k_lat=k. Outputs: hsync=1, vsync=1, video_on=0, pixel_rgb=0, x_vga=0, y_vga=0, flow_enabled=0, frame_start=0, pix_hold=0.
- Pixel slot: tick counts 0..3, wrapping every clock (25 MHz slot rate). Both counter pairs advance on the edge where tick==3.
- h: 0..799, wraps to 0 and increments v.
- v: 0..524, wraps to 0.
- Horizontal timing: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical timing: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- The request counter pair (rh,rv) follows the same wrap rules and stays exactly LOOKAHEAD slots ahead of (h,v) across line and frame wraps.
- k_lat: loaded from k only on the edge where the display counters wrap (799,524) -> (0,0). A k change mid-frame takes effect at the next frame; no tearing.
- Window geometry:
  - w = IMG_WIDTH>>k_lat, ht = IMG_HEIGHT>>k_lat.
  - x0 = (640-w)>>1, y0 = (480-ht)>>1.
  - in_win(p,q) = x0<=p<x0+w and y0<=q<y0+ht.
  - All comparisons use 10-bit unsigned arithmetic.
- Registered outputs update on the tick==3 edge with values for the new slot:
  - video_on = (h'<640 and v'<480).
  - hsync/vsync are low inside their sync ranges.
  - pixel_rgb: pix_hold if in_win(h',v'); BORDER_COLOR if active but outside the window; 0 in blanking.
  - frame_start = 1 for that one clock when (h',v')=(0,0).
- Request outputs update on the same edge for the new (rh',rv'):
  - flow_enabled = in_win(rh',rv').
  - x_vga = rh'-x0, y_vga = rv'-y0 when in window, else 0.
  - All three are held for the full 4-clock slot.
- pix_hold loads pixel_in on every clock where pixel_valid_in=1 and otherwise holds.
- If pixel_valid_in is simultaneous with the tick==3 edge, pixel_rgb takes the old pix_hold; the new value is captured for the next slot.
- Latency contract: upstream must return a pixel within LOOKAHEAD*4-1 clocks of the request. Later pixels display the last held value; no stall and no error flag. Multi-cycle block averaging at k>=2 violates this by design; the display simply repeats values.
- Reset asserted mid-frame: next clock shows reset values and timing restarts at (0,0).

Test Plan:
1. Reset, k=0, run one frame. Expect:
   - hsync low for exactly 96 slots (384 clocks) per line.
   - vsync low for lines 490..491.
   - 800x525 slots per frame; frame_start once per 1,680,000 clocks.
2. k=0, upstream model returns pixel_in = x_vga[7:0] with 4-clock latency. Expect:
   - pixel_rgb = h-240 for h in 240..399 on rows 180..299.
   - BORDER_COLOR elsewhere in the active area; 0 in blanking.
3. k=3. Expect window 20x15 at x0=310, y0=232; flow_enabled high only for request positions rh 310..329, rv 232..246.
4. Change k 0->1 at line 100. Expect:
   - Current frame keeps the 160x120 window.
   - From the next frame_start, 80x60 window at (280,210).
5. Upstream pixel_valid_in held low. Expect pixel_rgb to repeat the last pix_hold inside the window while sync timing is unaffected.
6. Assert reset for 1 clock at (h=500,v=300). Expect all outputs at reset values next clock and the first hsync low 656 slots later.

Source files
------------

// File: rtl/vga_zoom_if.sv
// Request/response link between the display stage and the zoom engine:
// the display asks for (x_vga, y_vga) and the engine answers with pixel_in/pixel_valid_in.
interface vga_zoom_if #(
   parameter int DATA_WIDTH = 8
);
   logic [9:0]            x_vga;
   logic [9:0]            y_vga;
   logic                  flow_enabled;
   logic [DATA_WIDTH-1:0] pixel_in;
   logic                  pixel_valid_in;

   modport master (
      output x_vga, y_vga, flow_enabled,
      input  pixel_in, pixel_valid_in
   );

   modport slave (
      input  x_vga, y_vga, flow_enabled,
      output pixel_in, pixel_valid_in
   );
endinterface

// File: rtl/vga_zoom_display.sv
// VGA display stage for the zoom-out path: 4-clock pixel slots, a request counter running
// LOOKAHEAD slots ahead of the display counter, and a centred IMG>>k window inside a border.
module vga_zoom_display #(
   parameter int                    IMG_WIDTH    = 160,
   parameter int                    IMG_HEIGHT   = 120,
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    LOOKAHEAD    = 2,
   parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = '0,
   parameter int                    H_VISIBLE    = 640,
   parameter int                    H_FRONT      = 16,
   parameter int                    H_SYNC       = 96,
   parameter int                    H_BACK       = 48,
   parameter int                    V_VISIBLE    = 480,
   parameter int                    V_FRONT      = 10,
   parameter int                    V_SYNC       = 2,
   parameter int                    V_BACK       = 33
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            k,
   vga_zoom_if.master            zif,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  video_on,
   output logic [DATA_WIDTH-1:0] pixel_rgb,
   output logic                  frame_start
);

   localparam logic [9:0] H_ACT  = 10'(H_VISIBLE);
   localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_ACT  = 10'(V_VISIBLE);
   localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] IMG_W  = 10'(IMG_WIDTH);
   localparam logic [9:0] IMG_H  = 10'(IMG_HEIGHT);

   logic [1:0]            tick;
   logic [9:0]            h, v, rh, rv;
   logic [9:0]            h_n, v_n, rh_n, rv_n;
   logic [1:0]            k_lat;
   logic [DATA_WIDTH-1:0] pix_hold;
   logic [9:0]            win_w, win_h, win_x0, win_y0;
   logic                  act_n, disp_in, req_in;

   function automatic logic in_win(input logic [9:0] p, q, wx0, wy0, ww, wh);
      return (p >= wx0) && (p < wx0 + ww) && (q >= wy0) && (q < wy0 + wh);
   endfunction

   // Next-slot positions and window geometry; geometry is frozen per frame through k_lat
   always_comb begin
      h_n     = (h == H_LAST) ? '0 : h + 10'd1;
      v_n     = (h != H_LAST) ? v : ((v == V_LAST) ? '0 : v + 10'd1);
      rh_n    = (rh == H_LAST) ? '0 : rh + 10'd1;
      rv_n    = (rh != H_LAST) ? rv : ((rv == V_LAST) ? '0 : rv + 10'd1);
      win_w   = IMG_W >> k_lat;
      win_h   = IMG_H >> k_lat;
      win_x0  = (H_ACT - win_w) >> 1;
      win_y0  = (V_ACT - win_h) >> 1;
      act_n   = (h_n < H_ACT) && (v_n < V_ACT);
      disp_in = in_win(h_n, v_n, win_x0, win_y0, win_w, win_h);
      req_in  = in_win(rh_n, rv_n, win_x0, win_y0, win_w, win_h);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tick             <= '0;
         h                <= '0;
         v                <= '0;
         rh               <= 10'(LOOKAHEAD);
         rv               <= '0;
         k_lat            <= k;
         hsync            <= 1'b1;
         vsync            <= 1'b1;
         video_on         <= 1'b0;
         pixel_rgb        <= '0;
         frame_start      <= 1'b0;
         pix_hold         <= '0;
         zif.x_vga        <= '0;
         zif.y_vga        <= '0;
         zif.flow_enabled <= 1'b0;
      end else begin
         tick        <= tick + 2'd1;
         frame_start <= 1'b0;
         if (zif.pixel_valid_in)
            pix_hold <= zif.pixel_in;
         // Slot boundary: pixel_rgb sees pix_hold before any same-edge capture
         if (tick == 2'd3) begin
            h         <= h_n;
            v         <= v_n;
            rh        <= rh_n;
            rv        <= rv_n;
            video_on  <= act_n;
            hsync     <= !((h_n >= H_SS) && (h_n < H_SE));
            vsync     <= !((v_n >= V_SS) && (v_n < V_SE));
            pixel_rgb <= disp_in ? pix_hold : (act_n ? BORDER_COLOR : '0);
            zif.flow_enabled <= req_in;
            zif.x_vga        <= req_in ? rh_n - win_x0 : '0;
            zif.y_vga        <= req_in ? rv_n - win_y0 : '0;
            if (h_n == '0 && v_n == '0) begin
               k_lat       <= k;
               frame_start <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_zoom_display.sv
// Directed bench for vga_zoom_display on a reduced 48x30-slot raster with a 16x12 image.
module tb_vga_zoom_display;

   localparam int HVIS = 32, HF = 2, HSW = 6, HB = 8;
   localparam int VVIS = 24, VF = 2, VSW = 2, VB = 2;
   localparam int HT = 48, VT = 30, FS = HT * VT;
   localparam int LA = 2;
   localparam logic [7:0] BC = 8'h5A;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] k = 2'd0;
   logic       hsync, vsync, video_on, frame_start;
   logic [7:0] pixel_rgb;

   vga_zoom_if #(.DATA_WIDTH(8)) zif();

   vga_zoom_display #(
      .IMG_WIDTH(16), .IMG_HEIGHT(12), .DATA_WIDTH(8), .LOOKAHEAD(LA), .BORDER_COLOR(BC),
      .H_VISIBLE(HVIS), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
      .V_VISIBLE(VVIS), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
   ) dut (
      .clk(clk), .reset(reset), .k(k), .zif(zif),
      .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .pixel_rgb(pixel_rgb), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int     total = 0, passed = 0;
   int     slot = 0, fs_cnt = 0, hold_err = 0;
   longint clk_cnt = 0, last_fs = -1, fs_gap = 0;
   bit     up_en = 1'b1;
   logic [8:0] pipe [4] = '{default: 9'h000};

   // Upstream engine: echoes x_vga[7:0] exactly 4 clocks after the request is seen
   always @(negedge clk) begin
      zif.pixel_valid_in = up_en & pipe[3][8];
      zif.pixel_in       = pipe[3][7:0];
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = {zif.flow_enabled, zif.x_vga[7:0]};
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, slot=%0d", slot);
      $fatal(1);
   end

   // Expected slot-level outputs: {hsync, vsync, video_on, pixel_rgb, flow, x_vga, y_vga}
   function automatic logic [31:0] exp_vec(input int s, input int gx0, input int gy0,
                                           input int gw, input int gh, input bit live,
                                           input logic [7:0] held);
      int h, v, rh, rv;
      logic hs, vs, act, inw, rin;
      logic [7:0] rgb;
      logic [9:0] xv, yv;
      h   = s % HT;
      v   = (s / HT) % VT;
      rh  = (s + LA) % HT;
      rv  = ((s + LA) / HT) % VT;
      hs  = !(h >= 34 && h < 40);
      vs  = !(v >= 26 && v < 28);
      act = (h < 32) && (v < 24);
      inw = (h >= gx0) && (h < gx0 + gw) && (v >= gy0) && (v < gy0 + gh);
      rin = (rh >= gx0) && (rh < gx0 + gw) && (rv >= gy0) && (rv < gy0 + gh);
      rgb = inw ? (live ? 8'(h - gx0) : held) : (act ? BC : 8'h00);
      xv  = rin ? 10'(rh - gx0) : 10'd0;
      yv  = rin ? 10'(rv - gy0) : 10'd0;
      return {hs, vs, act, rgb, rin, xv, yv};
   endfunction

   function automatic logic [31:0] cur_vec();
      return {hsync, vsync, video_on, pixel_rgb, zif.flow_enabled, zif.x_vga, zif.y_vga};
   endfunction

   // Advance one slot (4 clocks), ending on the negedge just after the slot edge
   task automatic adv();
      logic [20:0] r0;
      r0 = {zif.flow_enabled, zif.x_vga, zif.y_vga};
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         clk_cnt++;
         if (i < 3 && {zif.flow_enabled, zif.x_vga, zif.y_vga} !== r0) hold_err++;
         if (frame_start === 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) fs_gap = clk_cnt - last_fs;
            last_fs = clk_cnt;
         end
      end
      slot++;
   endtask

   task automatic test_reset();
      logic [32:0] a;
      reset = 1'b1;
      k = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      a = {hsync, vsync, video_on, pixel_rgb, zif.flow_enabled, zif.x_vga, zif.y_vga, frame_start};
      total++;
      if (a !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 10'd0, 1'b0})
         $display("FAIL reset_values: got %h want %h", a, {3'b110, 30'd0});
      else passed++;
      reset = 1'b0;
      slot = 0; clk_cnt = 0; last_fs = -1;
      adv();
      total++;
      if ({video_on, hsync, vsync} !== 3'b111)
         $display("FAIL first_slot: video_on/hsync/vsync got %b want 111", {video_on, hsync, vsync});
      else passed++;
   endtask

   task automatic test_timing();
      int nbad = 0, fslot = 0, hs_low = 0, vs_low = 0;
      logic [31:0] a, e, fa = '0, fe = '0;
      fs_cnt = 0; hold_err = 0;
      while (slot < FS) begin
         adv();
         e = exp_vec(slot, 8, 6, 16, 12, 1'b1, 8'h00);
         a = cur_vec();
         if (a !== e) begin
            if (nbad == 0) begin fa = a; fe = e; fslot = slot; end
            nbad++;
         end
         if (slot / HT == 3 && hsync === 1'b0) hs_low++;
         if (vsync === 1'b0) vs_low++;
      end
      total++;
      if (nbad != 0) $display("FAIL timing_vec: %0d bad slots, first %0d got %h want %h", nbad, fslot, fa, fe);
      else passed++;
      total++;
      if (hs_low != 6) $display("FAIL hsync_width: got %0d slots want 6", hs_low);
      else passed++;
      total++;
      if (vs_low != 96) $display("FAIL vsync_width: got %0d slots want 96", vs_low);
      else passed++;
      total++;
      if (fs_cnt != 1 || frame_start !== 1'b1)
         $display("FAIL frame_start_once: count %0d now %b want 1 and 1", fs_cnt, frame_start);
      else passed++;
      total++;
      if (hold_err != 0) $display("FAIL request_hold: got %0d changes want 0", hold_err);
      else passed++;
   endtask

   task automatic test_window_k0();
      int nbad = 0, fslot = 0, flows = 0;
      logic [31:0] a, e, fa = '0, fe = '0;
      fs_cnt = 0;
      while (slot < 2 * FS) begin
         adv();
         e = exp_vec(slot, 8, 6, 16, 12, 1'b1, 8'h00);
         a = cur_vec();
         if (a !== e) begin
            if (nbad == 0) begin fa = a; fe = e; fslot = slot; end
            nbad++;
         end
         if (zif.flow_enabled === 1'b1) flows++;
         if (slot == FS + 10 * HT + 20) begin
            total++;
            if (pixel_rgb !== 8'd12) $display("FAIL k0_pixel_20_10: got %0d want 12", pixel_rgb);
            else passed++;
         end
         if (slot == 2 * FS - 100) k = 2'd3;
      end
      total++;
      if (nbad != 0) $display("FAIL k0_vec: %0d bad slots, first %0d got %h want %h", nbad, fslot, fa, fe);
      else passed++;
      total++;
      if (flows != 192) $display("FAIL k0_flow_count: got %0d want 192", flows);
      else passed++;
      total++;
      if (fs_gap != 5760) $display("FAIL frame_period: got %0d clocks want 5760", fs_gap);
      else passed++;
   endtask

   task automatic test_k3();
      int nbad = 0, fslot = 0, flows = 0;
      logic [31:0] a, e, fa = '0, fe = '0;
      while (slot < 3 * FS) begin
         adv();
         e = exp_vec(slot, 15, 11, 2, 1, 1'b1, 8'h00);
         a = cur_vec();
         if (a !== e) begin
            if (nbad == 0) begin fa = a; fe = e; fslot = slot; end
            nbad++;
         end
         if (zif.flow_enabled === 1'b1) flows++;
         if (slot == 2 * FS + 11 * HT + 16) begin
            total++;
            if (pixel_rgb !== 8'd1) $display("FAIL k3_pixel_16_11: got %0d want 1", pixel_rgb);
            else passed++;
         end
         if (slot == 3 * FS - 50) k = 2'd0;
      end
      total++;
      if (nbad != 0) $display("FAIL k3_vec: %0d bad slots, first %0d got %h want %h", nbad, fslot, fa, fe);
      else passed++;
      total++;
      if (flows != 2) $display("FAIL k3_flow_count: got %0d want 2", flows);
      else passed++;
   endtask

   task automatic test_k_change();
      int nbad = 0, fslot = 0, flows0 = 0, flows1 = 0;
      logic [31:0] a, e, fa = '0, fe = '0;
      fs_cnt = 0; hold_err = 0;
      while (slot < 5 * FS) begin
         adv();
         if (slot < 4 * FS) e = exp_vec(slot, 8, 6, 16, 12, 1'b1, 8'h00);
         else               e = exp_vec(slot, 12, 9, 8, 6, 1'b1, 8'h00);
         a = cur_vec();
         if (a !== e) begin
            if (nbad == 0) begin fa = a; fe = e; fslot = slot; end
            nbad++;
         end
         if (zif.flow_enabled === 1'b1) begin
            if (slot < 4 * FS - LA) flows0++;
            else flows1++;
         end
         if (slot == 3 * FS + 10 * HT) k = 2'd1;
         if (slot == 3 * FS + 12 * HT + 8) begin
            total++;
            if (pixel_rgb !== 8'd0) $display("FAIL no_tearing_8_12: got %0d want 0", pixel_rgb);
            else passed++;
         end
         if (slot == 4 * FS + 6 * HT + 8) begin
            total++;
            if (pixel_rgb !== BC) $display("FAIL k1_border_8_6: got %h want %h", pixel_rgb, BC);
            else passed++;
         end
         if (slot == 4 * FS + 14 * HT + 19) begin
            total++;
            if (pixel_rgb !== 8'd7) $display("FAIL k1_pixel_19_14: got %0d want 7", pixel_rgb);
            else passed++;
         end
      end
      total++;
      if (nbad != 0) $display("FAIL kchg_vec: %0d bad slots, first %0d got %h want %h", nbad, fslot, fa, fe);
      else passed++;
      total++;
      if (flows0 != 192 || flows1 != 48)
         $display("FAIL kchg_flow_counts: got %0d/%0d want 192/48", flows0, flows1);
      else passed++;
      total++;
      if (fs_cnt != 2 || hold_err != 0)
         $display("FAIL kchg_frames_hold: frame_starts %0d hold changes %0d want 2 and 0", fs_cnt, hold_err);
      else passed++;
   endtask

   task automatic test_stall();
      int nbad = 0, fslot = 0;
      logic [31:0] a, e, fa = '0, fe = '0;
      up_en = 1'b0;
      while (slot < 5 * FS + 15 * HT + 20) begin
         adv();
         e = exp_vec(slot, 12, 9, 8, 6, 1'b0, 8'd7);
         a = cur_vec();
         if (a !== e) begin
            if (nbad == 0) begin fa = a; fe = e; fslot = slot; end
            nbad++;
         end
         if (slot == 5 * FS + 12 * HT + 15) begin
            total++;
            if (pixel_rgb !== 8'd7) $display("FAIL stall_repeat_15_12: got %0d want 7", pixel_rgb);
            else passed++;
         end
      end
      total++;
      if (nbad != 0) $display("FAIL stall_vec: %0d bad slots, first %0d got %h want %h", nbad, fslot, fa, fe);
      else passed++;
   endtask

   task automatic test_mid_reset();
      int first_low = -1;
      logic [32:0] a;
      total++;
      if (pixel_rgb !== BC || video_on !== 1'b1)
         $display("FAIL pre_reset_20_15: rgb %h video_on %b want %h 1", pixel_rgb, video_on, BC);
      else passed++;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = {hsync, vsync, video_on, pixel_rgb, zif.flow_enabled, zif.x_vga, zif.y_vga, frame_start};
      total++;
      if (a !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 10'd0, 10'd0, 1'b0})
         $display("FAIL mid_reset_values: got %h want %h", a, {3'b110, 30'd0});
      else passed++;
      reset = 1'b0;
      slot = 0; clk_cnt = 0; last_fs = -1;
      while (slot < 40) begin
         adv();
         if (first_low < 0 && hsync === 1'b0) first_low = slot;
      end
      total++;
      if (first_low != 34) $display("FAIL restart_first_hsync: got slot %0d want 34", first_low);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_timing();
      test_window_k0();
      test_k3();
      test_k_change();
      test_stall();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
